// File: rtl/mips_pkg.sv
// mips_pkg: core-wide constants and types shared by the fetch front end
package mips_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [5:0] OP_J = 6'h2;
  localparam logic [5:0] OP_JAL = 6'h3;
  typedef enum logic {IDLE, RUN} seq_state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
  } fetch_word_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {inst, pc_plus4} holding register; flush beats load beats unload
module fetch_skid_buf (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_flush,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc_plus4,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc_plus4
);
  logic r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc_plus4;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_valid <= 1'b0;
      r_inst <= '0;
      r_pc_plus4 <= '0;
    end else begin
      r_valid <= i_flush ? 1'b0 : i_load ? 1'b1 : i_unload ? 1'b0 : r_valid;
      if (i_load) begin
        r_inst <= i_inst;
        r_pc_plus4 <= i_pc_plus4;
      end
    end
  end
  assign o_valid = r_valid;
  assign o_inst = r_inst;
  assign o_pc_plus4 = r_pc_plus4;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, keeps one imem fetch in flight, buffers stalls in a skid entry
// and squashes wrong-path fetches after jump or exception redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [31:0]      i_imem_data,
  output logic             o_inst_valid,
  output logic [31:0]      o_inst,
  output logic [31:0]      o_pc_plus4,
  input  logic             i_stall,
  input  logic             i_pcsrc,
  input  logic [31:0]      i_jmp_addr,
  input  logic             i_resume_req,
  input  logic [31:0]      i_resume_addr,
  output logic [CNT_W-1:0] o_redirect_cnt
);
  import mips_pkg::*;
  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic r_req;
  logic r_squash;
  logic r_valid;
  logic [31:0] r_addr;
  logic [31:0] r_fetch_pc;
  fetch_word_t r_out;
  logic [CNT_W-1:0] r_cnt;
  logic w_ack;
  logic w_consume;
  logic w_resume;
  logic w_redirect;
  logic w_live;
  logic w_to_out;
  logic w_to_skid;
  logic w_unload;
  logic w_skid_valid;
  logic w_skid_nxt;
  logic [31:0] w_target;
  logic [31:0] w_skid_inst;
  logic [31:0] w_skid_pc4;
  logic w_req_nxt;
  logic w_squash_nxt;
  logic w_valid_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_fetch_pc_nxt;
  fetch_word_t w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  assign w_ack = r_req & i_imem_ack;
  assign w_consume = r_valid & ~i_stall;
  assign w_resume = i_resume_req & (r_state == RUN);
  assign w_redirect = w_resume | (w_consume & i_pcsrc);
  assign w_target = w_resume ? i_resume_addr : i_jmp_addr;
  // A redirect in the ack cycle drops the data directly instead of arming the squash flag
  assign w_live = w_ack & ~r_squash & ~w_redirect;
  assign w_to_out = w_live & (~r_valid | w_consume);
  assign w_to_skid = w_live & ~w_to_out;
  assign w_unload = w_consume & w_skid_valid & ~w_redirect;
  assign w_skid_nxt = ~w_redirect & (w_skid_valid ? ~w_consume : w_to_skid);
  fetch_skid_buf u_skid (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_load(w_to_skid),
    .i_unload(w_unload),
    .i_flush(w_redirect),
    .i_inst(i_imem_data),
    .i_pc_plus4(r_fetch_pc + 32'd4),
    .o_valid(w_skid_valid),
    .o_inst(w_skid_inst),
    .o_pc_plus4(w_skid_pc4)
  );
  always_comb begin
    w_state_nxt = RUN;
    w_fetch_pc_nxt = w_redirect ? w_target : w_live ? r_fetch_pc + 32'd4 : r_fetch_pc;
    w_req_nxt = r_req ? ~w_ack : ~w_skid_nxt;
    w_addr_nxt = (~r_req & ~w_skid_nxt) ? w_fetch_pc_nxt : r_addr;
    w_squash_nxt = r_req & ~w_ack & (r_squash | w_redirect);
    w_valid_nxt = ~w_redirect & (w_to_out | w_unload | (r_valid & ~w_consume));
    w_out_nxt = w_to_out ? fetch_word_t'({i_imem_data, r_fetch_pc + 32'd4}) :
                w_unload ? fetch_word_t'({w_skid_inst, w_skid_pc4}) : r_out;
    w_cnt_nxt = (w_redirect & ~(&r_cnt)) ? r_cnt + {{(CNT_W-1){1'b0}}, 1'b1} : r_cnt;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_squash <= 1'b0;
      r_valid <= 1'b0;
      r_out <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req <= w_req_nxt;
      r_addr <= w_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_squash <= w_squash_nxt;
      r_valid <= w_valid_nxt;
      r_out <= w_out_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  assign o_imem_req = r_req;
  assign o_imem_addr = r_addr;
  assign o_inst_valid = r_valid;
  assign o_inst = r_out.inst;
  assign o_pc_plus4 = r_out.pc_plus4;
  assign o_redirect_cnt = r_cnt;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed stimulus, queue-based fetch model checked every cycle, plus literal pins
module tb_pc_fetch_sequencer;
  localparam int CW = 3;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic pcsrc = 1'b0;
  logic resume = 1'b0;
  logic [31:0] jmp = '0;
  logic [31:0] raddr = '0;
  logic ack;
  logic [31:0] data;
  logic req;
  logic valid;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic [CW-1:0] cnt;
  int lat = 0;
  int wcnt = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction
  assign ack = req && (wcnt >= lat);
  assign data = mem(addr);
  always @(posedge clk) wcnt <= (!rst_n || !req || ack) ? 0 : wcnt + 1;
  pc_fetch_sequencer #(.CNT_W(CW)) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .o_imem_req(req),
    .o_imem_addr(addr),
    .i_imem_ack(ack),
    .i_imem_data(data),
    .o_inst_valid(valid),
    .o_inst(inst),
    .o_pc_plus4(pc4),
    .i_stall(stall),
    .i_pcsrc(pcsrc),
    .i_jmp_addr(jmp),
    .i_resume_req(resume),
    .i_resume_addr(raddr),
    .o_redirect_cnt(cnt)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  ent_t q[$];
  logic m_req = 1'b0;
  logic m_squash = 1'b0;
  logic m_run = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_pc = '0;
  logic [CW-1:0] m_cnt = '0;
  always @(posedge clk) begin : model
    logic a;
    logic cons;
    logic res;
    logic redir;
    if (!rst_n) begin
      q.delete();
      m_req = 1'b0;
      m_squash = 1'b0;
      m_run = 1'b0;
      m_addr = '0;
      m_pc = '0;
      m_cnt = '0;
    end else begin
      a = m_req && ack;
      cons = (q.size() != 0) && !stall;
      res = resume && m_run;
      redir = res || (cons && pcsrc);
      if (redir) begin
        q.delete();
        if (m_cnt != '1) m_cnt++;
      end else begin
        if (cons) void'(q.pop_front());
        if (a && !m_squash) q.push_back(ent_t'{mem(m_pc), m_pc + 32'd4});
      end
      if (redir) m_pc = res ? raddr : jmp;
      else if (a && !m_squash) m_pc = m_pc + 32'd4;
      m_squash = !a && (m_squash || (redir && m_req));
      if (m_req) m_req = !a;
      else if (q.size() < 2) begin
        m_req = 1'b1;
        m_addr = m_pc;
      end
      m_run = 1'b1;
    end
  end
  always @(negedge clk) begin
    chk("req", req, m_req);
    chk("addr", addr, m_addr);
    chk("valid", valid, q.size() != 0);
    chk("cnt", cnt, m_cnt);
    if (q.size() != 0) begin
      chk("inst", inst, q[0].inst);
      chk("pc4", pc4, q[0].pc4);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    tick(3);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc4", pc4, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    tick(1);
    chk("first_req", req, 1);
    chk("first_addr", addr, 0);
    tick(1);
    chk("zw_inst", inst, 32'h2000_0000);
    chk("zw_pc4", pc4, 4);
    chk("zw_valid", valid, 1);
    tick(1);
    chk("zw_addr2", addr, 4);
    lat = 3;
    stall = 1'b1;
    tick(3);
    chk("wait_addr", addr, 4);
    chk("wait_req", req, 1);
    tick(1);
    chk("st_inst", inst, 32'h2000_0004);
    tick(5);
    chk("skid_full_req", req, 0);
    chk("skid_hold_inst", inst, 32'h2000_0004);
    tick(1);
    chk("skid_full_req2", req, 0);
    stall = 1'b0;
    tick(1);
    chk("rel_inst", inst, 32'h2000_0008);
    chk("rel_pc4", pc4, 12);
    chk("rel_addr", addr, 12);
    lat = 0;
    tick(1);
    chk("rel_inst2", inst, 32'h2000_000C);
    tick(1);
    chk("seq_addr", addr, 16);
    lat = 2;
    tick(3);
    chk("pre_j_inst", inst, 32'h2000_0010);
    stall = 1'b1;
    tick(1);
    chk("inflight_addr", addr, 20);
    stall = 1'b0;
    pcsrc = 1'b1;
    jmp = 32'h40;
    tick(1);
    chk("j_valid", valid, 0);
    chk("j_cnt", cnt, 1);
    pcsrc = 1'b0;
    tick(2);
    chk("j_gap_valid", valid, 0);
    chk("j_gap_req", req, 0);
    tick(1);
    chk("j_addr", addr, 32'h40);
    tick(3);
    chk("j_inst", inst, 32'h2000_0040);
    stall = 1'b1;
    pcsrc = 1'b1;
    jmp = 32'h100;
    tick(1);
    chk("stall_pcsrc_cnt", cnt, 1);
    chk("stall_pcsrc_addr", addr, 32'h44);
    tick(3);
    chk("stall_pcsrc_inst", inst, 32'h2000_0040);
    stall = 1'b0;
    tick(1);
    chk("late_j_addr", addr, 32'h100);
    chk("late_j_cnt", cnt, 2);
    pcsrc = 1'b0;
    lat = 0;
    tick(1);
    chk("t100_inst", inst, 32'h2000_0100);
    stall = 1'b1;
    tick(1);
    chk("pre_res_addr", addr, 32'h104);
    stall = 1'b0;
    pcsrc = 1'b1;
    jmp = 32'h200;
    resume = 1'b1;
    raddr = 32'h180;
    tick(1);
    chk("res_valid", valid, 0);
    chk("res_cnt", cnt, 3);
    resume = 1'b0;
    pcsrc = 1'b0;
    tick(1);
    chk("res_addr", addr, 32'h180);
    tick(1);
    chk("res_inst", inst, 32'h2000_0180);
    resume = 1'b1;
    raddr = 32'hFFFF_FFFC;
    tick(1);
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    resume = 1'b0;
    tick(1);
    chk("wrap_pc4", pc4, 0);
    chk("wrap_inst", inst, 32'h1FFF_FFFC);
    tick(1);
    chk("wrap_next_addr", addr, 0);
    lat = 5;
    tick(1);
    chk("midrst_req", req, 1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_req0", req, 0);
    chk("midrst_cnt", cnt, 0);
    rst_n = 1'b1;
    lat = 0;
    resume = 1'b1;
    raddr = 32'h300;
    tick(1);
    chk("restart_addr", addr, 0);
    chk("restart_req", req, 1);
    tick(6);
    chk("idle_res_cnt", cnt, 6);
    tick(3);
    chk("sat_cnt", cnt, 7);
    resume = 1'b0;
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
